mem_writeback: RTL and testbench

- Writeback stage directly downstream of the memory-access stage.
- Consumes that stage's done pulse, instruction control struct, loaded data and ALU result.
- Selects the writeback value and writes the register file through a ready/valid port.
- Buffers pending writes in a small FIFO, exposes the youngest pending write for forwarding, counts retired instructions and detects halt.

---
 rtl/mem_writeback_pkg.sv | 25 ++
 rtl/wb_fifo.sv | 56 +++++
 rtl/mem_writeback.sv | 96 +++++++++
 tb/tb_mem_writeback.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_writeback_pkg.sv
// Shared types for the writeback stage: instruction control struct and memory-op encoding.
// No logic; types and widths only.
// Consumers import with mem_writeback_pkg::*.
package mem_writeback_pkg;

   localparam int RF_AW = 5;

   typedef enum logic [1:0] {
      MEM_OP_NONE = 2'd0,
      MEM_OP_LW   = 2'd1,
      MEM_OP_SW   = 2'd2
   } mem_op_e;

   typedef struct packed {
      mem_op_e mem_op;
      logic    rf_we;
      logic    is_halt;
   } f_dec_t;

   typedef struct packed {
      logic [RF_AW-1:0] reg_dest;
      f_dec_t           f_dec;
   } instr_structure;

endpackage

// File: rtl/wb_fifo.sv
// Pending-write FIFO with head and youngest-entry (tail-1) read ports.
// Latency: a pushed entry is visible at head/tail the cycle after the push edge.
// Backpressure: a push while full is dropped unless a pop happens in the same cycle.
module wb_fifo #(
   parameter int W     = 37,
   parameter int DEPTH = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] din,
   output logic         full,
   output logic         empty,
   output logic [W-1:0] head,
   output logic [W-1:0] tail
);

   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   cnt;
   logic          do_push;
   logic          do_pop;

   assign full    = (cnt == (AW+1)'(DEPTH));
   assign empty   = (cnt == '0);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign head    = mem[rd_ptr];
   assign tail    = mem[wr_ptr - AW'(1)];

   // Storage and pointer/occupancy update; storage is cleared so outputs read zero after reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= din;
            wr_ptr      <= wr_ptr + AW'(1);
         end
         if (do_pop) rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   cnt <= cnt + (AW+1)'(1);
            2'b01:   cnt <= cnt - (AW+1)'(1);
            default: cnt <= cnt;
         endcase
      end
   end

endmodule

// File: rtl/mem_writeback.sv
// Writeback stage: picks load/ALU value, queues register-file writes, forwards youngest pending write.
// Latency: write request 1 cycle after accept; done_out 1 cycle after accept.
// Backpressure: rf_wr_ready stalls the head; wb_stall tells upstream the queue is full.
module mem_writeback
   import mem_writeback_pkg::*;
#(
   parameter int DATA_W    = 32,
   parameter int REG_AW    = 5,
   parameter int BUF_DEPTH = 2,
   parameter int CNT_W     = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              done_in,
   input  instr_structure    iCont_in,
   input  logic [DATA_W-1:0] loadedData_in,
   input  logic [DATA_W-1:0] resultIn,
   input  logic              rf_wr_ready,
   output logic              rfWriteEn,
   output logic [REG_AW-1:0] rfWriteAddr,
   output logic [DATA_W-1:0] rfWriteData,
   output logic              fwd_valid,
   output logic [REG_AW-1:0] fwd_addr,
   output logic [DATA_W-1:0] fwd_data,
   output logic              wb_stall,
   output logic              overflow_err,
   output logic [CNT_W-1:0]  retired_count,
   output logic              halted,
   output logic              done_out
);

   localparam int ENT_W = REG_AW + DATA_W;

   logic              accept;
   logic              need_wr;
   logic              push;
   logic              pop;
   logic              full;
   logic              empty;
   logic              halt_pending;
   logic [REG_AW-1:0] dest;
   logic [DATA_W-1:0] wr_value;
   logic [ENT_W-1:0]  head;
   logic [ENT_W-1:0]  tail;

   // Accept/push decode; once a halt is pending, arrivals are ignored entirely.
   always_comb begin
      dest     = REG_AW'(iCont_in.reg_dest);
      accept   = done_in && !halt_pending && !halted;
      need_wr  = iCont_in.f_dec.rf_we && (dest != '0) && (iCont_in.f_dec.mem_op != MEM_OP_SW);
      wr_value = (iCont_in.f_dec.mem_op == MEM_OP_LW) ? loadedData_in : resultIn;
      pop      = !empty && rf_wr_ready;
      push     = accept && need_wr && !wb_stall;
   end

   assign wb_stall    = full && !pop;
   assign rfWriteEn   = !empty;
   assign rfWriteAddr = head[DATA_W +: REG_AW];
   assign rfWriteData = head[DATA_W-1:0];
   assign fwd_valid   = !empty;
   assign fwd_addr    = tail[DATA_W +: REG_AW];
   assign fwd_data    = tail[DATA_W-1:0];

   wb_fifo #(
      .W     (ENT_W),
      .DEPTH (BUF_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .pop   (pop),
      .din   ({dest, wr_value}),
      .full  (full),
      .empty (empty),
      .head  (head),
      .tail  (tail)
   );

   // Retirement count, sticky overflow, halt tracking and the accept pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         retired_count <= '0;
         overflow_err  <= 1'b0;
         halt_pending  <= 1'b0;
         halted        <= 1'b0;
         done_out      <= 1'b0;
      end else begin
         retired_count <= retired_count + CNT_W'(pop) + CNT_W'(accept && !need_wr);
         if (accept && wb_stall) overflow_err <= 1'b1;
         if (accept && iCont_in.f_dec.is_halt) halt_pending <= 1'b1;
         if (halt_pending && empty) halted <= 1'b1;
         done_out <= accept;
      end
   end

endmodule

// File: tb/tb_mem_writeback.sv
module tb_mem_writeback;
   import mem_writeback_pkg::*;

   localparam int DEPTH = 2;

   logic           clk = 1'b0;
   logic           rst_n;
   logic           done_in;
   instr_structure iCont_in;
   logic [31:0]    loadedData_in;
   logic [31:0]    resultIn;
   logic           rf_wr_ready;
   logic           rfWriteEn;
   logic [4:0]     rfWriteAddr;
   logic [31:0]    rfWriteData;
   logic           fwd_valid;
   logic [4:0]     fwd_addr;
   logic [31:0]    fwd_data;
   logic           wb_stall;
   logic           overflow_err;
   logic [31:0]    retired_count;
   logic           halted;
   logic           done_out;

   mem_writeback dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .done_in       (done_in),
      .iCont_in      (iCont_in),
      .loadedData_in (loadedData_in),
      .resultIn      (resultIn),
      .rf_wr_ready   (rf_wr_ready),
      .rfWriteEn     (rfWriteEn),
      .rfWriteAddr   (rfWriteAddr),
      .rfWriteData   (rfWriteData),
      .fwd_valid     (fwd_valid),
      .fwd_addr      (fwd_addr),
      .fwd_data      (fwd_data),
      .wb_stall      (wb_stall),
      .overflow_err  (overflow_err),
      .retired_count (retired_count),
      .halted        (halted),
      .done_out      (done_out)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int en_seen, wr_seen, done_seen;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   // Reference model: pending writes as a queue of {dest, data}, plus architectural counters.
   logic [36:0] m_q[$];
   logic [31:0] m_cnt;
   logic        m_ovf, m_hp, m_halted, m_done;
   logic        m_pop, m_stall, m_acc, m_need;
   logic [31:0] m_val;

   always @(negedge clk) begin
      if (!rst_n) begin
         m_q.delete();
         m_cnt = 0; m_ovf = 0; m_hp = 0; m_halted = 0; m_done = 0;
      end else begin
         chk("wr_en", rfWriteEn, m_q.size() > 0);
         chk("fwd_valid", fwd_valid, m_q.size() > 0);
         if (m_q.size() > 0) begin
            chk("wr_addr", rfWriteAddr, m_q[0][36:32]);
            chk("wr_data", rfWriteData, m_q[0][31:0]);
            chk("fwd_addr", fwd_addr, m_q[m_q.size()-1][36:32]);
            chk("fwd_data", fwd_data, m_q[m_q.size()-1][31:0]);
         end
         m_pop   = (m_q.size() > 0) && rf_wr_ready;
         m_stall = (m_q.size() == DEPTH) && !m_pop;
         chk("wb_stall", wb_stall, m_stall);
         chk("retired", retired_count, m_cnt);
         chk("overflow", overflow_err, m_ovf);
         chk("halted", halted, m_halted);
         chk("done_out", done_out, m_done);
         if (done_out) done_seen++;
         if (rfWriteEn) en_seen++;
         if (rfWriteEn && rf_wr_ready) wr_seen++;
         // advance model across the coming rising edge
         m_acc  = done_in && !m_hp;
         m_need = iCont_in.f_dec.rf_we && (iCont_in.reg_dest != 0) &&
                  (iCont_in.f_dec.mem_op != MEM_OP_SW);
         m_val  = (iCont_in.f_dec.mem_op == MEM_OP_LW) ? loadedData_in : resultIn;
         if (m_hp && m_q.size() == 0) m_halted = 1;
         if (m_pop) begin void'(m_q.pop_front()); m_cnt = m_cnt + 1; end
         if (m_acc && !m_need) m_cnt = m_cnt + 1;
         if (m_acc && m_stall) m_ovf = 1;
         if (m_acc && m_need && !m_stall) m_q.push_back({iCont_in.reg_dest, m_val});
         if (m_acc && iCont_in.f_dec.is_halt) m_hp = 1;
         m_done = m_acc;
      end
   end

   task automatic set_in(input logic d, input logic [4:0] dst, input mem_op_e op, input logic we,
                         input logic h, input logic [31:0] ld, input logic [31:0] res);
      done_in                = d;
      iCont_in.reg_dest      = dst;
      iCont_in.f_dec.mem_op  = op;
      iCont_in.f_dec.rf_we   = we;
      iCont_in.f_dec.is_halt = h;
      loadedData_in          = ld;
      resultIn               = res;
   endtask

   task automatic cyc(input logic d, input logic [4:0] dst, input mem_op_e op, input logic we,
                      input logic h, input logic [31:0] ld, input logic [31:0] res, input logic rdy);
      @(posedge clk); #1;
      rf_wr_ready = rdy;
      set_in(d, dst, op, we, h, ld, res);
   endtask

   task automatic idle(input logic rdy, input int n);
      for (int i = 0; i < n; i++) cyc(0, 0, MEM_OP_NONE, 0, 0, 0, 0, rdy);
   endtask

   task automatic chk_zero(input string nm);
      chk(nm, {rfWriteEn, rfWriteAddr, rfWriteData, fwd_valid, fwd_addr, fwd_data, wb_stall,
               overflow_err, retired_count, halted, done_out}, '0);
   endtask

   task automatic do_reset();
      rst_n = 0;
      rf_wr_ready = 0;
      set_in(0, 0, MEM_OP_NONE, 0, 0, 0, 0);
      @(negedge clk);
      chk_zero("reset_state");
      @(negedge clk); #1;
      rst_n = 1;
      en_seen = 0; wr_seen = 0; done_seen = 0;
   endtask

   initial begin
      rst_n = 1;
      #2;
      // LW to r5: head and forward next cycle, retired after pop
      do_reset();
      cyc(1, 5, MEM_OP_LW, 1, 0, 32'hDEADBEEF, 32'h100, 1);
      idle(1, 1);
      @(negedge clk);
      chk("t1_en", rfWriteEn, 1'b1);
      chk("t1_addr", rfWriteAddr, 5'd5);
      chk("t1_data", rfWriteData, 32'hDEADBEEF);
      chk("t1_fwd", fwd_addr, 5'd5);
      idle(1, 1);
      @(negedge clk);
      chk("t1_count", retired_count, 32'd1);

      // writes to r0 and stores never reach the register file
      do_reset();
      cyc(1, 0, MEM_OP_NONE, 1, 0, 0, 32'h55, 1);
      cyc(1, 7, MEM_OP_SW, 1, 0, 0, 32'h66, 1);
      idle(1, 3);
      @(negedge clk);
      chk("t2_count", retired_count, 32'd2);
      chk("t2_done", done_seen, 2);
      chk("t2_en", en_seen, 0);

      // overflow when full and blocked
      do_reset();
      cyc(1, 1, MEM_OP_NONE, 1, 0, 0, 1, 0);
      cyc(1, 2, MEM_OP_NONE, 1, 0, 0, 2, 0);
      cyc(1, 3, MEM_OP_NONE, 1, 0, 0, 3, 0);
      @(negedge clk);
      chk("t3_stall", wb_stall, 1'b1);
      idle(0, 1);
      @(negedge clk);
      chk("t3_ovf", overflow_err, 1'b1);
      idle(1, 3);
      @(negedge clk);
      chk("t3_count", retired_count, 32'd2);
      chk("t3_writes", wr_seen, 2);

      // push and pop together while full
      do_reset();
      cyc(1, 1, MEM_OP_NONE, 1, 0, 0, 7, 0);
      cyc(1, 2, MEM_OP_NONE, 1, 0, 0, 8, 0);
      cyc(1, 4, MEM_OP_NONE, 1, 0, 0, 9, 1);
      @(negedge clk);
      chk("t4_stall", wb_stall, 1'b0);
      idle(1, 3);
      @(negedge clk);
      chk("t4_ovf", overflow_err, 1'b0);
      chk("t4_count", retired_count, 32'd3);

      // halt behind two pending writes, later arrival ignored
      do_reset();
      cyc(1, 1, MEM_OP_NONE, 1, 0, 0, 11, 0);
      cyc(1, 2, MEM_OP_NONE, 1, 0, 0, 12, 0);
      cyc(1, 0, MEM_OP_NONE, 0, 1, 0, 0, 0);
      idle(0, 1);
      @(negedge clk);
      chk("t5_not_halted", halted, 1'b0);
      cyc(1, 3, MEM_OP_NONE, 1, 0, 0, 3, 1);
      idle(1, 4);
      @(negedge clk);
      chk("t5_halted", halted, 1'b1);
      chk("t5_done", done_seen, 3);
      chk("t5_count", retired_count, 32'd3);
      chk("t5_writes", wr_seen, 2);

      // asynchronous reset mid-drain
      do_reset();
      cyc(1, 1, MEM_OP_NONE, 1, 0, 0, 21, 0);
      cyc(1, 2, MEM_OP_NONE, 1, 0, 0, 22, 0);
      idle(0, 1);
      @(posedge clk); #1;
      set_in(0, 0, MEM_OP_NONE, 0, 0, 0, 0);
      rf_wr_ready = 1;
      #2 rst_n = 0;
      #1 chk_zero("t6_async_reset");
      @(negedge clk);
      @(negedge clk); #1;
      rst_n = 1;
      en_seen = 0;
      idle(1, 3);
      @(negedge clk);
      chk("t6_en", en_seen, 0);
      chk("t6_count", retired_count, 32'd0);

      // random traffic with an upstream that honours wb_stall
      do_reset();
      for (int i = 0; i < 600; i++) begin
         @(posedge clk); #1;
         rf_wr_ready = ($urandom_range(0, 3) != 0);
         #1;
         if (!wb_stall && $urandom_range(0, 1) == 1)
            set_in(1, ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
                   mem_op_e'($urandom_range(0, 2)), 1'($urandom_range(0, 3) != 0), 0,
                   $urandom, $urandom);
         else
            set_in(0, 0, MEM_OP_NONE, 0, 0, 0, 0);
      end
      idle(1, 6);
      @(negedge clk);
      chk("rand_drained", rfWriteEn, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
